// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard FSM (load-use stall, branch flush, memory wait)
// with saturating stall/redirect performance counters.
module hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  id_instr,
    input  logic [XLEN-1:0]  ex_instr,
    input  logic             branch_en,
    input  logic [XLEN-1:0]  branch_addr,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             halt,
    output logic             taken_branch,
    output logic             fetch_stall,
    output logic             pc_load,
    output logic [XLEN-1:0]  pc_target,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [2:0] {RUN, LD_STALL, FLUSH1, FLUSH2, MEM_WAIT} state_t;
    state_t state, next;
    logic [6:0] id_op;
    logic [4:0] ex_rd;
    logic rs1_used, rs2_used, load_use, take;
    logic unused_bits;
    assign id_op = id_instr[6:0];
    assign ex_rd = ex_instr[11:7];
    assign rs1_used = id_op inside {7'b0110011, 7'b0010011, 7'b1100011, 7'b1100111, 7'b0000011, 7'b0100011};
    assign rs2_used = id_op inside {7'b0110011, 7'b1100011, 7'b0100011};
    assign load_use = ex_instr[6:0] == 7'b0000011 && ex_rd != 5'd0 &&
                      ((rs1_used && id_instr[19:15] == ex_rd) || (rs2_used && id_instr[24:20] == ex_rd));
    // execute can only raise a redirect while it is not halted
    assign take = branch_en && (state == RUN || state == FLUSH1 || state == FLUSH2);
    assign unused_bits = ^{id_instr[XLEN-1:25], id_instr[14:7], ex_instr[XLEN-1:12]};
    always_comb begin
        next = state;
        case (state)
            RUN:      next = take ? FLUSH1 : mem_busy ? MEM_WAIT : load_use ? LD_STALL : RUN;
            LD_STALL: next = mem_busy ? MEM_WAIT : RUN;
            FLUSH1:   next = take ? FLUSH1 : FLUSH2;
            FLUSH2:   next = take ? FLUSH1 : mem_busy ? MEM_WAIT : RUN;
            MEM_WAIT: next = mem_busy ? MEM_WAIT : RUN;
            default:  next = RUN;
        endcase
    end
    assign halt         = state == LD_STALL || state == MEM_WAIT;
    assign fetch_stall  = halt;
    assign taken_branch = state == FLUSH1 || state == FLUSH2;
    assign pc_load      = state == FLUSH1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            pc_target <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= next;
            if (take) pc_target <= branch_addr;
            stall_cnt <= cnt_clr ? '0 : (halt && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
            flush_cnt <= cnt_clr ? '0 : (take && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table-driven bench for hazard_ctrl; a 4-bit-counter
// twin instance shares the stimulus to reach redirect-counter saturation quickly.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr, ex_instr, branch_addr;
    logic        branch_en, mem_busy, cnt_clr;
    logic        halt, taken_branch, fetch_stall, pc_load;
    logic [31:0] pc_target;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_halt, s_taken, s_fstall, s_pcl;
    logic [31:0] s_target;
    logic [3:0]  s_stall, s_flush;
    int checks = 0, errors = 0;
    int exp_stall = 0, exp_flush = 0, hcount;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .ex_instr(ex_instr),
        .branch_en(branch_en), .branch_addr(branch_addr), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .halt(halt), .taken_branch(taken_branch),
        .fetch_stall(fetch_stall), .pc_load(pc_load), .pc_target(pc_target),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    hazard_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_instr(id_instr), .ex_instr(ex_instr),
        .branch_en(branch_en), .branch_addr(branch_addr), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .halt(s_halt), .taken_branch(s_taken),
        .fetch_stall(s_fstall), .pc_load(s_pcl), .pc_target(s_target),
        .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ex;
        logic [31:0] id;
        logic        stall;
    } vec_t;
    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic h, input logic tb, input logic pl);
        chk({name, ".halt"}, {31'd0, halt}, {31'd0, h});
        chk({name, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, h});
        chk({name, ".taken_branch"}, {31'd0, taken_branch}, {31'd0, tb});
        chk({name, ".pc_load"}, {31'd0, pc_load}, {31'd0, pl});
    endtask

    initial begin
        // lw x5,0(x1) = 0000A283 ; add x6,x5,x2 = 00228333
        vecs[0]  = '{32'h0000A283, 32'h00228333, 1'b1};
        vecs[1]  = '{32'h0000A003, 32'h00200333, 1'b0}; // lw x0 / add x6,x0,x2
        vecs[2]  = '{32'h0000A283, 32'h000282B7, 1'b0}; // lui x5 with rs1 field = 5
        vecs[3]  = '{32'h0000A283, 32'h0072A023, 1'b1}; // sw x7,0(x5)
        vecs[4]  = '{32'h0000A283, 32'h0050A023, 1'b1}; // sw x5,0(x1) via rs2
        vecs[5]  = '{32'h0000A283, 32'h00128313, 1'b1}; // addi x6,x5,1
        vecs[6]  = '{32'h0000A283, 32'h00508313, 1'b0}; // addi x6,x1,5 : rs2 field ignored
        vecs[7]  = '{32'h0000A283, 32'h00508063, 1'b1}; // beq x1,x5
        vecs[8]  = '{32'h0000A283, 32'h000280E7, 1'b1}; // jalr x1,0(x5)
        vecs[9]  = '{32'h0000A283, 32'h0002A303, 1'b1}; // lw x6,0(x5)
        vecs[10] = '{32'h0000A283, 32'h00208333, 1'b0}; // add x6,x1,x2
        vecs[11] = '{32'h002082B3, 32'h00228333, 1'b0}; // ex is add, not a load
        vecs[12] = '{32'h0000A303, 32'h00228333, 1'b0}; // lw x6 vs add using x5,x2
        rst = 1'b0; id_instr = '0; ex_instr = '0; branch_en = 0;
        branch_addr = '0; mem_busy = 0; cnt_clr = 0;
        #3;
        chk_ctl("reset", 0, 0, 0);
        chk("reset.pc_target", pc_target, 0);
        chk("reset.stall_cnt", {16'd0, stall_cnt}, 0);
        chk("reset.flush_cnt", {16'd0, flush_cnt}, 0);
        rst = 1'b1;
        step();
        foreach (vecs[i]) begin
            ex_instr = vecs[i].ex; id_instr = vecs[i].id;
            step();
            chk_ctl($sformatf("lu%0d", i), vecs[i].stall, 0, 0);
            ex_instr = '0; id_instr = '0;
            step();
            chk_ctl($sformatf("lu%0d.after", i), 0, 0, 0);
            exp_stall += int'(vecs[i].stall);
            chk($sformatf("lu%0d.stall_cnt", i), {16'd0, stall_cnt}, exp_stall);
        end
        // simple branch
        branch_en = 1; branch_addr = 32'h100;
        step();
        branch_en = 0; branch_addr = 32'hDEAD;
        chk_ctl("br.n1", 0, 1, 1);
        chk("br.n1.target", pc_target, 32'h100);
        step();
        chk_ctl("br.n2", 0, 1, 0);
        step();
        chk_ctl("br.n3", 0, 0, 0);
        chk("br.hold_target", pc_target, 32'h100);
        exp_flush = 1;
        chk("br.flush_cnt", {16'd0, flush_cnt}, exp_flush);
        // branch + load-use + mem_busy together
        branch_en = 1; branch_addr = 32'h200; mem_busy = 1;
        ex_instr = 32'h0000A283; id_instr = 32'h00228333;
        step();
        branch_en = 0;
        chk_ctl("combo.f1", 0, 1, 1);
        step();
        chk_ctl("combo.f2", 0, 1, 0);
        step();
        chk_ctl("combo.mw1", 1, 0, 0);
        step();
        chk_ctl("combo.mw2", 1, 0, 0);
        mem_busy = 0; ex_instr = '0; id_instr = '0;
        step();
        chk_ctl("combo.run", 0, 0, 0);
        exp_flush++; exp_stall += 2;
        chk("combo.flush_cnt", {16'd0, flush_cnt}, exp_flush);
        chk("combo.stall_cnt", {16'd0, stall_cnt}, exp_stall);
        // mem_busy: one entry cycle plus five busy cycles inside MEM_WAIT
        hcount = 0;
        mem_busy = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 5) mem_busy = 0;
            if (halt) hcount++;
        end
        chk("mw.halt_cycles", hcount, 6);
        exp_stall += 6;
        chk("mw.stall_cnt", {16'd0, stall_cnt}, exp_stall);
        // redirect from FLUSH2, load-use ignored while flushing
        branch_en = 1; branch_addr = 32'h300;
        step();
        branch_en = 0;
        step();
        chk_ctl("rf.f2", 0, 1, 0);
        branch_en = 1; branch_addr = 32'h400;
        step();
        branch_en = 0;
        chk_ctl("rf.f1b", 0, 1, 1);
        chk("rf.target", pc_target, 32'h400);
        ex_instr = 32'h0000A283; id_instr = 32'h00228333;
        step();
        chk_ctl("rf.f2b", 0, 1, 0);
        step();
        chk_ctl("rf.no_lu", 0, 0, 0);
        ex_instr = '0; id_instr = '0;
        exp_flush += 2;
        chk("rf.flush_cnt", {16'd0, flush_cnt}, exp_flush);
        chk("rf.stall_cnt", {16'd0, stall_cnt}, exp_stall);
        // cnt_clr beats a same-cycle increment
        mem_busy = 1;
        step();
        cnt_clr = 1;
        step();
        chk("clr.stall_cnt", {16'd0, stall_cnt}, 0);
        chk("clr.flush_cnt", {16'd0, flush_cnt}, 0);
        cnt_clr = 0; mem_busy = 0;
        step();
        chk("clr.after", {16'd0, stall_cnt}, 1);
        // stall counter saturation
        mem_busy = 1;
        for (int k = 0; k < 65540; k++) step();
        chk("sat.stall_cnt", {16'd0, stall_cnt}, 32'hFFFF);
        chk("sat.small_stall", {28'd0, s_stall}, 32'hF);
        mem_busy = 0;
        step();
        step();
        chk("sat.stall_hold", {16'd0, stall_cnt}, 32'hFFFF);
        // redirect counter saturation: a held branch_en re-enters FLUSH1 every cycle
        branch_en = 1; branch_addr = 32'h80;
        for (int k = 0; k < 20; k++) step();
        branch_en = 0;
        chk("sat.flush_cnt", {16'd0, flush_cnt}, 20);
        chk("sat.small_flush", {28'd0, s_flush}, 32'hF);
        step();
        step();
        // asynchronous reset in FLUSH1
        branch_en = 1; branch_addr = 32'h500;
        step();
        branch_en = 0;
        chk_ctl("ar.f1", 0, 1, 1);
        #2 rst = 1'b0;
        #1;
        chk_ctl("ar.async", 0, 0, 0);
        chk("ar.pc_target", pc_target, 0);
        chk("ar.stall_cnt", {16'd0, stall_cnt}, 0);
        chk("ar.flush_cnt", {16'd0, flush_cnt}, 0);
        step();
        rst = 1'b1;
        step();
        chk_ctl("ar.release", 0, 0, 0);
        step();
        chk_ctl("ar.release2", 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
